// File: rtl/ysyx_22040759_mem_arbiter_pkg.sv
// ysyx_22040759_define
// Shared encodings for the unified memory arbiter: FSM state codes and the
// transaction owner tag recorded at grant time.
package ysyx_22040759_define;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/ysyx_22040759_mem_arbiter_arb_prio.sv
// ysyx_22040759_arb_prio
// Fixed-priority pick (LSU over IF) with a starvation guard for IF.
// The streak counter counts consecutive LSU grants taken while IF was waiting.
// Once it reaches STARVE_MAX, IF wins the next contested arbitration.
// Ports:
//   clk, rst        clock / asynchronous active-low reset
//   arb_en          arbitration allowed this cycle (arbiter is idle)
//   if_req_valid    IF request pending
//   lsu_req_valid   LSU request pending
//   grant_if        IF wins this cycle (combinational)
//   grant_lsu       LSU wins this cycle (combinational)
//   streak          current streak counter value
import ysyx_22040759_define::*;

module ysyx_22040759_arb_prio #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arb_en,
    input  logic             if_req_valid,
    input  logic             lsu_req_valid,
    output logic             grant_if,
    output logic             grant_lsu,
    output logic [CNT_W-1:0] streak
);

    localparam logic [CNT_W-1:0] STREAK_MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] streak_r;

    // Combinational pick; at most one grant is ever high.
    always_comb begin
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        if (!arb_en) begin
            grant_if  = 1'b0;
            grant_lsu = 1'b0;
        end else if (lsu_req_valid && if_req_valid) begin
            if (streak_r == STREAK_MAX_C) begin
                grant_if = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else if (lsu_req_valid) begin
            grant_lsu = 1'b1;
        end else if (if_req_valid) begin
            grant_if = 1'b1;
        end else begin
            grant_if  = 1'b0;
            grant_lsu = 1'b0;
        end
    end

    // Streak counter: grows only while IF is kept waiting, clears otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_r <= {CNT_W{1'b0}};
        end else if (grant_lsu && if_req_valid) begin
            if (streak_r != STREAK_MAX_C) begin
                streak_r <= streak_r + CNT_W'(1);
            end
        end else if (grant_if || grant_lsu) begin
            streak_r <= {CNT_W{1'b0}};
        end
    end

    assign streak = streak_r;

endmodule

// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter
// Shares one variable-latency memory port between instruction fetch (read
// only) and the load/store unit (read/write). One transaction in flight.
// Ports:
//   clk, rst                      clock / asynchronous active-low reset
//   if_req_valid/ready, if_addr   IF request handshake and address
//   if_resp_valid                 IF response pulse
//   lsu_req_valid/ready, lsu_*    LSU request handshake and payload
//   lsu_resp_valid                LSU read data / write done pulse
//   resp_rdata                    shared response data (mem_rdata)
//   mem_req_valid/ready, mem_*    latched request towards the slave
//   mem_resp_valid, mem_rdata     slave response
import ysyx_22040759_define::*;

module ysyx_22040759_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W  = $clog2(STARVE_MAX + 1);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e          state_r;
    arb_state_e          state_next_s;
    arb_owner_e          owner_r;
    logic                mem_req_valid_r;
    logic                mem_req_valid_next_s;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_wen_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [STRB_W-1:0]   mem_wstrb_r;
    logic                arb_en_s;
    logic                grant_if_s;
    logic                grant_lsu_s;
    logic                resp_fire_s;
    logic [CNT_W-1:0]    streak_s;

    assign arb_en_s = (state_r == ARB_IDLE);

    ysyx_22040759_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .clk           (clk),
        .rst           (rst),
        .arb_en        (arb_en_s),
        .if_req_valid  (if_req_valid),
        .lsu_req_valid (lsu_req_valid),
        .grant_if      (grant_if_s),
        .grant_lsu     (grant_lsu_s),
        .streak        (streak_s)
    );

    // Next-state logic and response detection.
    always_comb begin
        state_next_s = state_r;
        resp_fire_s  = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (grant_if_s || grant_lsu_s) begin
                    state_next_s = ARB_ISSUE;
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                // A response before the request is accepted is not ours.
                if (mem_req_ready) begin
                    if (mem_resp_valid) begin
                        resp_fire_s  = 1'b1;
                        state_next_s = ARB_IDLE;
                    end else begin
                        state_next_s = ARB_WAIT;
                    end
                end else begin
                    state_next_s = ARB_ISSUE;
                end
            end
            ARB_WAIT: begin
                if (mem_resp_valid) begin
                    resp_fire_s  = 1'b1;
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = ARB_WAIT;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
        mem_req_valid_next_s = (state_next_s == ARB_ISSUE);
    end

    // State register plus registered mem_req_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ARB_IDLE;
            mem_req_valid_r <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            mem_req_valid_r <= mem_req_valid_next_s;
        end
    end

    // Request latch: captures the winner's payload and records the owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= OWN_IF;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wen_r   <= 1'b0;
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= {STRB_W{1'b0}};
        end else if (grant_lsu_s) begin
            owner_r     <= OWN_LSU;
            mem_addr_r  <= lsu_addr;
            mem_wen_r   <= lsu_wen;
            mem_wdata_r <= lsu_wdata;
            mem_wstrb_r <= lsu_wstrb;
        end else if (grant_if_s) begin
            owner_r     <= OWN_IF;
            mem_addr_r  <= if_addr;
            mem_wen_r   <= 1'b0;
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_wstrb_r <= {STRB_W{1'b0}};
        end
    end

    // Grants are gated with rst so nothing handshakes while reset is held.
    assign if_req_ready   = rst & grant_if_s;
    assign lsu_req_ready  = rst & grant_lsu_s;
    assign if_resp_valid  = resp_fire_s & (owner_r == OWN_IF);
    assign lsu_resp_valid = resp_fire_s & (owner_r == OWN_LSU);
    assign resp_rdata     = rst ? mem_rdata : {DATA_W{1'b0}};
    assign mem_req_valid  = mem_req_valid_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wen        = mem_wen_r;
    assign mem_wdata      = mem_wdata_r;
    assign mem_wstrb      = mem_wstrb_r;

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
module tb_ysyx_22040759_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid;
    logic [63:0] if_addr;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_22040759_mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_ready   (if_req_ready),
        .if_addr        (if_addr),
        .if_resp_valid  (if_resp_valid),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wstrb      (lsu_wstrb),
        .lsu_resp_valid (lsu_resp_valid),
        .resp_rdata     (resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks follow 2ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [6:0] exp_v;
        int       lsu_left;
        int       k;
        exp_v = 7'b1101111;

        rst = 1'b0;
        if_req_valid = 1'b0; if_addr = 64'd0;
        lsu_req_valid = 1'b0; lsu_addr = 64'd0; lsu_wen = 1'b0;
        lsu_wdata = 64'd0; lsu_wstrb = 8'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;

        // Reset state: requests during reset are not accepted.
        repeat (2) @(posedge clk);
        #1;
        if_req_valid = 1'b1; lsu_req_valid = 1'b1;
        #2;
        check_eq("rst_if_ready", if_req_ready, 64'd0);
        check_eq("rst_lsu_ready", lsu_req_ready, 64'd0);
        check_eq("rst_mem_valid", mem_req_valid, 64'd0);
        check_eq("rst_mem_addr", mem_addr, 64'd0);
        check_eq("rst_state", dut.state_r, 64'd0);
        check_eq("rst_streak", dut.u_prio.streak_r, 64'd0);
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // IF-only read with 1-cycle-latency slave.
        if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0000;
        #2;
        check_eq("t1_if_ready_c0", if_req_ready, 64'd1);
        check_eq("t1_lsu_ready_c0", lsu_req_ready, 64'd0);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #2;
        check_eq("t1_mem_valid_c1", mem_req_valid, 64'd1);
        check_eq("t1_mem_addr", mem_addr, 64'h0000_0000_8000_0000);
        check_eq("t1_mem_wstrb", mem_wstrb, 64'd0);
        check_eq("t1_if_resp_c1", if_resp_valid, 64'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0010_0073_0000_0413;
        #2;
        check_eq("t1_if_resp_c2", if_resp_valid, 64'd1);
        check_eq("t1_lsu_resp_c2", lsu_resp_valid, 64'd0);
        check_eq("t1_rdata", resp_rdata, 64'h0010_0073_0000_0413);
        check_eq("t1_mem_valid_c2", mem_req_valid, 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #2;
        check_eq("t1_if_resp_c3", if_resp_valid, 64'd0);

        // Simultaneous requests: LSU first, IF only after lsu_resp_valid.
        if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0004;
        lsu_req_valid = 1'b1; lsu_addr = 64'h0000_0000_8000_1000; lsu_wen = 1'b0;
        #2;
        check_eq("t2_lsu_ready", lsu_req_ready, 64'd1);
        check_eq("t2_if_ready", if_req_ready, 64'd0);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #2;
        check_eq("t2_mem_addr_lsu", mem_addr, 64'h0000_0000_8000_1000);
        check_eq("t2_if_ready_issue", if_req_ready, 64'd0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h1234;
        #2;
        check_eq("t2_lsu_resp", lsu_resp_valid, 64'd1);
        check_eq("t2_if_resp", if_resp_valid, 64'd0);
        check_eq("t2_if_ready_wait", if_req_ready, 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #2;
        check_eq("t2_if_ready_idle", if_req_ready, 64'd1);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #2;
        check_eq("t2_mem_addr_if", mem_addr, 64'h0000_0000_8000_0004);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #2;
        check_eq("t2_if_resp_done", if_resp_valid, 64'd1);
        tick();
        mem_resp_valid = 1'b0;

        // Starvation guard: IF held, LSU issues 6 reads -> LSU x4, IF, LSU x2.
        if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0008;
        lsu_req_valid = 1'b1; lsu_addr = 64'h0000_0000_8000_2000;
        lsu_left = 6;
        for (int i = 0; i < 7; i++) begin
            #2;
            if (i == 4) check_eq("t3_streak_before_if", dut.u_prio.streak_r, 64'd4);
            check_eq($sformatf("t3_lsu_grant%0d", i), lsu_req_ready, {63'd0, exp_v[i]});
            check_eq($sformatf("t3_if_grant%0d", i), if_req_ready, {63'd0, ~exp_v[i]});
            tick();
            k = 6 - lsu_left;
            if (exp_v[i]) begin
                lsu_left--;
                lsu_req_valid = (lsu_left != 0);
                lsu_addr = lsu_addr + 64'd8;
            end else begin
                if_req_valid = 1'b0;
            end
            mem_req_ready = 1'b1;
            #2;
            check_eq($sformatf("t3_mem_addr%0d", i), mem_addr,
                     exp_v[i] ? 64'h0000_0000_8000_2000 + 64'(k * 8) : 64'h0000_0000_8000_0008);
            if (i == 4) check_eq("t3_streak_after_if", dut.u_prio.streak_r, 64'd0);
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'(i);
            #2;
            check_eq($sformatf("t3_lsu_resp%0d", i), lsu_resp_valid, {63'd0, exp_v[i]});
            check_eq($sformatf("t3_if_resp%0d", i), if_resp_valid, {63'd0, ~exp_v[i]});
            tick();
            mem_resp_valid = 1'b0;
        end

        // LSU write with 3 cycles of slave backpressure.
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h0000_0000_8000_3000;
        lsu_wdata = 64'hDEAD_BEEF_CAFE_F00D; lsu_wstrb = 8'h0F;
        #2;
        check_eq("t4_lsu_ready", lsu_req_ready, 64'd1);
        tick();
        lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_wdata = 64'd0; lsu_wstrb = 8'd0;
        lsu_addr = 64'd0;
        for (int j = 0; j < 3; j++) begin
            mem_resp_valid = (j == 1);
            #2;
            check_eq($sformatf("t4_valid%0d", j), mem_req_valid, 64'd1);
            check_eq($sformatf("t4_addr%0d", j), mem_addr, 64'h0000_0000_8000_3000);
            check_eq($sformatf("t4_wdata%0d", j), mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
            check_eq($sformatf("t4_wstrb%0d", j), mem_wstrb, 64'h0F);
            check_eq($sformatf("t4_wen%0d", j), mem_wen, 64'd1);
            check_eq($sformatf("t4_early_resp%0d", j), lsu_resp_valid, 64'd0);
            tick();
        end
        mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
        #2;
        check_eq("t4_valid_accept", mem_req_valid, 64'd1);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #2;
        check_eq("t4_lsu_resp", lsu_resp_valid, 64'd1);
        check_eq("t4_if_resp", if_resp_valid, 64'd0);
        check_eq("t4_valid_wait", mem_req_valid, 64'd0);
        tick();
        #2;
        check_eq("t4_lsu_resp_once", lsu_resp_valid, 64'd0);
        mem_resp_valid = 1'b0;
        tick();

        // Zero-latency slave: accept and respond in the first ISSUE cycle.
        if_req_valid = 1'b1; if_addr = 64'h0000_0000_8000_0010;
        #2;
        check_eq("t5_if_ready", if_req_ready, 64'd1);
        tick();
        if_req_valid = 1'b0; mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
        mem_rdata = 64'h1122_3344_5566_7788;
        #2;
        check_eq("t5_if_resp", if_resp_valid, 64'd1);
        check_eq("t5_rdata", resp_rdata, 64'h1122_3344_5566_7788);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        lsu_req_valid = 1'b1; lsu_addr = 64'h0000_0000_8000_4000; lsu_wen = 1'b0;
        #2;
        check_eq("t5_state_idle", dut.state_r, 64'd0);
        check_eq("t5_mem_valid", mem_req_valid, 64'd0);
        check_eq("t5_regrant", lsu_req_ready, 64'd1);

        // Reset while in WAIT, then a late response after reset.
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #2;
        check_eq("t6_mem_valid", mem_req_valid, 64'd1);
        tick();
        mem_req_ready = 1'b0;
        #2;
        check_eq("t6_state_wait", dut.state_r, 64'd2);
        #2;
        rst = 1'b0; mem_resp_valid = 1'b1;
        #1;
        check_eq("t6_rst_mem_valid", mem_req_valid, 64'd0);
        check_eq("t6_rst_mem_addr", mem_addr, 64'd0);
        check_eq("t6_rst_lsu_resp", lsu_resp_valid, 64'd0);
        check_eq("t6_rst_state", dut.state_r, 64'd0);
        tick();
        #1;
        rst = 1'b1;
        #1;
        check_eq("t6_late_lsu_resp", lsu_resp_valid, 64'd0);
        check_eq("t6_late_if_resp", if_resp_valid, 64'd0);
        check_eq("t6_late_mem_valid", mem_req_valid, 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        #2;
        check_eq("t6_final_state", dut.state_r, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
